// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module : hazard_forward_unit
// Desc   : Decode-stage load-use stall, pipeline flush and registered
//          EX-stage forwarding-select controller.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_forward_unit #(
  parameter int CNT_W  = 16,
  parameter int RA_REG = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [1:0]       how_many_ops,
  input  logic [1:0]       op1_src,
  input  logic [1:0]       op2_src,
  input  logic             reg_write,
  input  logic [1:0]       reg_dest,
  input  logic             load_signal,
  input  logic [1:0]       jump,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0]       c_fwd_none  = 2'b00;
  localparam logic [1:0]       c_fwd_exmem = 2'b01;
  localparam logic [1:0]       c_fwd_memwb = 2'b10;
  localparam logic [4:0]       c_ra_reg    = 5'(RA_REG);
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;

  // Only EX and MEM producers are held: a WB producer never changes a select
  // because the register file writes before it is read.
  logic             r_ex_valid;
  logic [4:0]       r_ex_dst;
  logic             r_ex_load;
  logic             r_mem_valid;
  logic [4:0]       r_mem_dst;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_stall_count;

  logic       w_src1_used;
  logic       w_src2_used;
  logic [4:0] w_src1;
  logic [4:0] w_src2;
  logic [4:0] w_dst;
  logic       w_record;
  logic       w_a_ex;
  logic       w_a_mem;
  logic       w_b_ex;
  logic       w_b_mem;
  logic       w_stall;
  logic       w_enter;
  logic [1:0] w_a_sel;
  logic [1:0] w_b_sel;

  function automatic logic hit(input logic used, input logic [4:0] src,
                               input logic slot_valid, input logic [4:0] slot_dst);
    return used && (src != 5'd0) && slot_valid && (src == slot_dst);
  endfunction

  always_comb begin
    w_src1_used = (how_many_ops != 2'd0);
    w_src2_used = (how_many_ops == 2'd2);
    w_src1      = (op1_src == 2'b01) ? rt : rs;
    w_src2      = (op2_src == 2'b10) ? rd : rt;

    w_dst = 5'd0;
    case (reg_dest)
      2'b00:   w_dst = rt;
      2'b01:   w_dst = rd;
      2'b10:   w_dst = c_ra_reg;
      default: w_dst = 5'd0;
    endcase
    w_record = reg_write && (w_dst != 5'd0);

    w_a_ex  = hit(w_src1_used, w_src1, r_ex_valid,  r_ex_dst);
    w_a_mem = hit(w_src1_used, w_src1, r_mem_valid, r_mem_dst);
    w_b_ex  = hit(w_src2_used, w_src2, r_ex_valid,  r_ex_dst);
    w_b_mem = hit(w_src2_used, w_src2, r_mem_valid, r_mem_dst);

    w_stall = id_valid && r_ex_load && (w_a_ex || w_b_ex) && !ex_redirect;
    w_enter = id_valid && !w_stall && !ex_redirect;

    // An EX-slot match at capture time is never a load (that case stalls).
    w_a_sel = w_a_ex ? c_fwd_exmem : (w_a_mem ? c_fwd_memwb : c_fwd_none);
    w_b_sel = w_b_ex ? c_fwd_exmem : (w_b_mem ? c_fwd_memwb : c_fwd_none);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_dst      <= 5'd0;
      r_ex_load     <= 1'b0;
      r_mem_valid   <= 1'b0;
      r_mem_dst     <= 5'd0;
      r_fwd_a       <= c_fwd_none;
      r_fwd_b       <= c_fwd_none;
      r_stall_count <= '0;
    end else begin
      r_mem_valid <= r_ex_valid;
      r_mem_dst   <= r_ex_dst;
      if (w_enter) begin
        r_ex_valid <= w_record;
        r_ex_dst   <= w_dst;
        r_ex_load  <= w_record && load_signal;
        r_fwd_a    <= w_a_sel;
        r_fwd_b    <= w_b_sel;
      end else begin
        r_ex_valid <= 1'b0;
        r_ex_dst   <= 5'd0;
        r_ex_load  <= 1'b0;
        r_fwd_a    <= c_fwd_none;
        r_fwd_b    <= c_fwd_none;
      end
      if (w_stall && (r_stall_count != c_cnt_max)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign stall       = w_stall;
  assign flush_idex  = ex_redirect;
  assign flush_ifid  = ex_redirect || ((jump == 2'b01) && id_valid && !w_stall);
  assign fwd_a_sel   = r_fwd_a;
  assign fwd_b_sel   = r_fwd_b;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_forward_unit
// Desc   : Self-checking bench: directed vector table, async-reset sequence,
//          then random traffic against a pipeline-occupancy reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  rs, rt, rd;
  logic [1:0]  how_many_ops, op1_src, op2_src, reg_dest, jump;
  logic        reg_write, load_signal, ex_redirect;
  logic        stall, flush_ifid, flush_idex;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count;

  hazard_forward_unit #(.CNT_W(16), .RA_REG(31)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs(rs), .rt(rt), .rd(rd),
    .how_many_ops(how_many_ops), .op1_src(op1_src), .op2_src(op2_src),
    .reg_write(reg_write), .reg_dest(reg_dest), .load_signal(load_signal),
    .jump(jump), .ex_redirect(ex_redirect), .stall(stall),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v, rs, rt, rd, nops, op1, op2, rw, rdst, ld, jmp, redir;
    int e_st, e_fi, e_fx, e_a, e_b, e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: occupancy of EX/MEM/WB, index 0 = youngest.
  int m_v[3], m_d[3], m_l[3];
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int v, int rs_, int rt_, int rd_, int nops, int op1, int op2,
                              int rw, int rdst, int ld, int jmp, int redir,
                              int st, int fi, int fx, int a, int b, int cnt);
    vec_t x;
    x.v = v; x.rs = rs_; x.rt = rt_; x.rd = rd_; x.nops = nops; x.op1 = op1; x.op2 = op2;
    x.rw = rw; x.rdst = rdst; x.ld = ld; x.jmp = jmp; x.redir = redir;
    x.e_st = st; x.e_fi = fi; x.e_fx = fx; x.e_a = a; x.e_b = b; x.e_cnt = cnt;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    id_valid = x.v[0]; rs = 5'(x.rs); rt = 5'(x.rt); rd = 5'(x.rd);
    how_many_ops = 2'(x.nops); op1_src = 2'(x.op1); op2_src = 2'(x.op2);
    reg_write = x.rw[0]; reg_dest = 2'(x.rdst); load_signal = x.ld[0];
    jump = 2'(x.jmp); ex_redirect = x.redir[0];
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin m_v[k] = 0; m_d[k] = 0; m_l[k] = 0; end
    m_cnt = 0;
  endfunction

  function automatic int src_reg(int n);
    if (n == 1) return (how_many_ops >= 1) ? ((op1_src == 2'b01) ? int'(rt) : int'(rs)) : 0;
    return (how_many_ops == 2) ? ((op2_src == 2'b10) ? int'(rd) : int'(rt)) : 0;
  endfunction

  // Youngest in-flight producer decides; a WB producer means "read regfile".
  function automatic int sel_for(int s);
    if (s == 0) return 0;
    for (int k = 0; k < 3; k++)
      if (m_v[k] != 0 && m_d[k] == s) return (k == 0) ? 1 : ((k == 1) ? 2 : 0);
    return 0;
  endfunction

  function automatic int m_stall();
    int s1, s2;
    s1 = src_reg(1); s2 = src_reg(2);
    if (!id_valid || ex_redirect || m_v[0] == 0 || m_l[0] == 0) return 0;
    return ((s1 != 0 && s1 == m_d[0]) || (s2 != 0 && s2 == m_d[0])) ? 1 : 0;
  endfunction

  task automatic model_step(output int ea, output int eb);
    int st, enter, dst;
    st    = m_stall();
    enter = (id_valid && st == 0 && !ex_redirect) ? 1 : 0;
    ea    = enter ? sel_for(src_reg(1)) : 0;
    eb    = enter ? sel_for(src_reg(2)) : 0;
    if (st != 0 && m_cnt < 65535) m_cnt++;
    dst = (reg_dest == 2'b00) ? int'(rt) : (reg_dest == 2'b01) ? int'(rd) :
          (reg_dest == 2'b10) ? 31 : 0;
    for (int k = 2; k > 0; k--) begin m_v[k] = m_v[k-1]; m_d[k] = m_d[k-1]; m_l[k] = m_l[k-1]; end
    m_v[0] = (enter != 0 && reg_write && dst != 0) ? 1 : 0;
    m_d[0] = dst;
    m_l[0] = int'(load_signal);
  endtask

  initial begin
    int ea, eb;
    vec_t z;
    z = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
    drive(z);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fwd_a", fwd_a_sel, 0);
    chk("reset_fwd_b", fwd_b_sel, 0);
    chk("reset_count", stall_count, 0);
    chk("reset_stall", stall, 0);
    rst = 1'b0;

    // v rs rt rd nops op1 op2 rw rdst ld jmp redir | st fi fx a b cnt
    tbl.push_back(mk(1, 0, 1, 0,2'd1,0,0,1,0,0,0,0, 0,0,0,0,0,0)); // addi r1
    tbl.push_back(mk(1, 1, 1, 2,2'd2,0,1,1,1,0,0,0, 0,0,0,1,1,0)); // add r2,r1,r1
    tbl.push_back(mk(0, 0, 0, 0,0,   0,0,0,0,0,0,0, 0,0,0,0,0,0)); // bubble
    tbl.push_back(mk(1, 0, 3, 0,1,   0,0,1,0,1,0,0, 0,0,0,0,0,0)); // lw r3
    tbl.push_back(mk(1, 3, 5, 4,2,   0,1,1,1,0,0,0, 1,0,0,0,0,1)); // sub r4,r3,r5 stalls
    tbl.push_back(mk(1, 3, 5, 4,2,   0,1,1,1,0,0,0, 0,0,0,2,0,1)); // retry: fwd from MEM
    tbl.push_back(mk(1, 0, 1, 0,1,   0,0,1,0,0,0,0, 0,0,0,0,0,1)); // addi r1
    tbl.push_back(mk(1, 2, 2, 1,2,   0,1,1,1,0,0,0, 0,0,0,0,0,1)); // add r1,r2,r2
    tbl.push_back(mk(1, 1, 1, 6,2,   0,1,1,1,0,0,0, 0,0,0,1,1,1)); // or r6: youngest wins
    tbl.push_back(mk(1, 0, 0, 0,1,   0,0,1,0,0,0,0, 0,0,0,0,0,1)); // addi r0
    tbl.push_back(mk(1, 0, 0, 2,2,   0,1,1,1,0,0,0, 0,0,0,0,0,1)); // add r2,r0,r0
    tbl.push_back(mk(1, 0, 0, 0,0,   0,0,1,2,0,1,0, 0,1,0,0,0,1)); // jal
    tbl.push_back(mk(1,31, 0, 7,2,   0,1,1,1,0,0,0, 0,0,0,1,0,1)); // add r7,r31,r0
    tbl.push_back(mk(1, 0, 3, 0,1,   0,0,1,0,1,0,0, 0,0,0,0,0,1)); // lw r3
    tbl.push_back(mk(1, 3, 5, 4,2,   0,1,1,1,0,0,1, 0,1,1,0,0,1)); // consumer + redirect
    tbl.push_back(mk(0, 0, 0, 0,0,   0,0,0,0,0,0,0, 0,0,0,0,0,1)); // bubble
    tbl.push_back(mk(1, 0, 9, 0,1,   0,0,1,0,0,0,0, 0,0,0,0,0,1)); // addi r9
    tbl.push_back(mk(1, 0, 9, 9,2,   1,2,0,0,0,0,0, 0,0,0,1,1,1)); // op1=rt, op2=rd
    tbl.push_back(mk(1, 0, 5, 0,1,   0,0,1,0,1,0,0, 0,0,0,0,0,1)); // lw r5
    tbl.push_back(mk(1, 5, 0, 0,1,   0,0,0,0,0,1,0, 1,0,0,0,0,2)); // jump stalled: no flush
    tbl.push_back(mk(1, 5, 0, 0,1,   0,0,0,0,0,1,0, 0,1,0,2,0,2)); // jump retried: flush
    tbl.push_back(mk(1, 0, 3, 0,1,   0,0,1,0,0,0,0, 0,0,0,0,0,2)); // addi r3
    tbl.push_back(mk(1, 3, 3, 0,1,   0,0,1,0,1,0,0, 0,0,0,1,0,2)); // lw r3,0(r3)

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), stall, tbl[i].e_st);
      chk($sformatf("vec%0d_flush_ifid", i), flush_ifid, tbl[i].e_fi);
      chk($sformatf("vec%0d_flush_idex", i), flush_idex, tbl[i].e_fx);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_fwd_a", i), fwd_a_sel, tbl[i].e_a);
      chk($sformatf("vec%0d_fwd_b", i), fwd_b_sel, tbl[i].e_b);
      chk($sformatf("vec%0d_count", i), stall_count, tbl[i].e_cnt);
    end

    // Async reset between edges with lw r3 in EX and its consumer in ID.
    drive(mk(1, 3, 3, 3, 2, 0, 1, 1, 1, 0, 0, 0, 0,0,0,0,0,0));
    #1;
    chk("prerst_stall", stall, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_stall", stall, 0);
    chk("rst_async_fwd_a", fwd_a_sel, 0);
    chk("rst_async_count", stall_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_stall", stall, 0);
    @(posedge clk);
    #1;
    chk("postrst_fwd_a", fwd_a_sel, 0);
    chk("postrst_fwd_b", fwd_b_sel, 0);
    chk("postrst_count", stall_count, 0);

    drive(z);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 400; i++) begin
      id_valid     = ($urandom_range(0, 7) != 0);
      rs           = 5'($urandom_range(0, 7));
      rt           = 5'($urandom_range(0, 7));
      rd           = 5'($urandom_range(0, 7));
      how_many_ops = 2'($urandom_range(0, 2));
      op1_src      = 2'($urandom_range(0, 1));
      op2_src      = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      reg_write    = ($urandom_range(0, 3) != 0);
      reg_dest     = 2'($urandom_range(0, 2));
      load_signal  = ($urandom_range(0, 2) == 0);
      jump         = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
      ex_redirect  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      chk("rnd_stall", stall, m_stall());
      chk("rnd_flush_idex", flush_idex, ex_redirect);
      chk("rnd_flush_ifid", flush_ifid,
          (ex_redirect || (jump == 2'b01 && id_valid && m_stall() == 0)) ? 1 : 0);
      model_step(ea, eb);
      @(posedge clk);
      #1;
      chk("rnd_fwd_a", fwd_a_sel, ea);
      chk("rnd_fwd_b", fwd_b_sel, eb);
      chk("rnd_count", stall_count, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
